// File: rtl/mem_responder.sv
// Memory-side responder: one shared word RAM answering data reads and instruction
// fetches after a fixed latency, while committing write-through stores every cycle.
module mem_responder #(
  parameter int    AW      = 12,
  parameter int    LATENCY = 2,
  parameter string INIT    = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_iaddr,
  input  logic        i_iread_en,
  output logic [31:0] o_inst,
  output logic        o_iread_vd,
  input  logic [31:0] i_memaddr,
  input  logic        i_read_en,
  output logic [31:0] o_read_data,
  output logic        o_read_vd,
  input  logic        i_write_en,
  input  logic [31:0] i_write_data,
  output logic        o_busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int            CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [31:0]   ram [0:(2**AW)-1];

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          src_q, src_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   inst_q, inst_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [AW-1:0] dword;
  logic [AW-1:0] iword;
  logic [31:0]   rd_word;
  logic          entering_resp;
  logic          unused_addr_bits;

  assign dword = i_memaddr[AW+1:2];
  assign iword = i_iaddr[AW+1:2];
  assign unused_addr_bits = ^{i_memaddr[31:AW+2], i_memaddr[1:0],
                              i_iaddr[31:AW+2], i_iaddr[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    addr_d  = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (i_read_en || i_iread_en) begin
          src_d  = i_read_en;
          addr_d = i_read_en ? dword : iword;
          if (LATENCY == 1) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Response data is captured on the edge into RESP; a store to the same word
  // on that edge must win over the stale RAM contents.
  always_comb begin
    inst_d        = inst_q;
    rdata_d       = rdata_q;
    entering_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
    rd_word       = (i_write_en && (dword == addr_d)) ? i_write_data : ram[addr_d];
    if (entering_resp) begin
      if (src_d) rdata_d = rd_word;
      else       inst_d  = rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      src_q   <= 1'b0;
      addr_q  <= '0;
      inst_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      addr_q  <= addr_d;
      inst_q  <= inst_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (i_write_en) ram[dword] <= i_write_data;
  end

  assign o_busy      = (state_q != ST_IDLE);
  assign o_read_vd   = (state_q == ST_RESP) && src_q;
  assign o_iread_vd  = (state_q == ST_RESP) && !src_q;
  assign o_inst      = inst_q;
  assign o_read_data = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: main instance (AW=12, LATENCY=2) plus a
// small wrap/short-latency instance (AW=4, LATENCY=1).
module tb_mem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] iaddr, inst, memaddr, read_data, write_data;
   logic        iread_en, iread_vd, read_en, read_vd, write_en, busy;
   logic [31:0] b_iaddr, b_inst, b_memaddr, b_read_data, b_write_data;
   logic        b_iread_en, b_iread_vd, b_read_en, b_read_vd, b_write_en, b_busy;

   int checks = 0;
   int failures = 0;

   mem_responder #(.AW(12), .LATENCY(2)) dut (
      .clk(clk), .rst(rst),
      .i_iaddr(iaddr), .i_iread_en(iread_en), .o_inst(inst), .o_iread_vd(iread_vd),
      .i_memaddr(memaddr), .i_read_en(read_en), .o_read_data(read_data), .o_read_vd(read_vd),
      .i_write_en(write_en), .i_write_data(write_data), .o_busy(busy)
   );

   mem_responder #(.AW(4), .LATENCY(1)) dut_b (
      .clk(clk), .rst(rst),
      .i_iaddr(b_iaddr), .i_iread_en(b_iread_en), .o_inst(b_inst), .o_iread_vd(b_iread_vd),
      .i_memaddr(b_memaddr), .i_read_en(b_read_en), .o_read_data(b_read_data), .o_read_vd(b_read_vd),
      .i_write_en(b_write_en), .i_write_data(b_write_data), .o_busy(b_busy)
   );

   // Advance to just after the next rising edge: outputs now show the new cycle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [31:0] a, input logic [31:0] d);
      memaddr = a; write_data = d; write_en = 1'b1;
      step();
      write_en = 1'b0;
   endtask

   task automatic test_reset();
      step(); step();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (iread_vd !== 1'b0) begin failures++; $display("FAIL rst_iread_vd: got %b want 0", iread_vd); end
      checks++; if (read_vd !== 1'b0) begin failures++; $display("FAIL rst_read_vd: got %b want 0", read_vd); end
      checks++; if (inst !== 32'h0) begin failures++; $display("FAIL rst_inst: got %h want 0", inst); end
      checks++; if (read_data !== 32'h0) begin failures++; $display("FAIL rst_read_data: got %h want 0", read_data); end
      checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL rst_b_busy: got %b want 0", b_busy); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_fetch();
      write_word(32'h10, 32'hDEADBEEF);
      iaddr = 32'h10; iread_en = 1'b1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fetch_c0_busy: got %b want 0", busy); end
      step();
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL fetch_c1_busy: got %b want 1", busy); end
      checks++; if (iread_vd !== 1'b0) begin failures++; $display("FAIL fetch_c1_vd: got %b want 0", iread_vd); end
      step();
      checks++; if (iread_vd !== 1'b1) begin failures++; $display("FAIL fetch_c2_vd: got %b want 1", iread_vd); end
      checks++; if (inst !== 32'hDEADBEEF) begin failures++; $display("FAIL fetch_c2_inst: got %h want deadbeef", inst); end
      checks++; if (read_vd !== 1'b0) begin failures++; $display("FAIL fetch_c2_read_vd: got %b want 0", read_vd); end
      iread_en = 1'b0;
      step();
      checks++; if (iread_vd !== 1'b0) begin failures++; $display("FAIL fetch_c3_vd: got %b want 0", iread_vd); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fetch_c3_busy: got %b want 0", busy); end
      checks++; if (inst !== 32'hDEADBEEF) begin failures++; $display("FAIL fetch_c3_inst_hold: got %h want deadbeef", inst); end
   endtask

   task automatic test_priority();
      write_word(32'h30, 32'hA5A50001);
      memaddr = 32'h30; read_en = 1'b1; iaddr = 32'h10; iread_en = 1'b1;
      step(); step();
      checks++; if (read_vd !== 1'b1) begin failures++; $display("FAIL prio_c2_read_vd: got %b want 1", read_vd); end
      checks++; if (read_data !== 32'hA5A50001) begin failures++; $display("FAIL prio_c2_data: got %h want a5a50001", read_data); end
      checks++; if (iread_vd !== 1'b0) begin failures++; $display("FAIL prio_c2_iread_vd: got %b want 0", iread_vd); end
      read_en = 1'b0;
      step();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL prio_c3_busy: got %b want 0", busy); end
      step();
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL prio_c4_busy: got %b want 1", busy); end
      checks++; if (iread_vd !== 1'b0) begin failures++; $display("FAIL prio_c4_iread_vd: got %b want 0", iread_vd); end
      step();
      checks++; if (iread_vd !== 1'b1) begin failures++; $display("FAIL prio_c5_iread_vd: got %b want 1", iread_vd); end
      checks++; if (inst !== 32'hDEADBEEF) begin failures++; $display("FAIL prio_c5_inst: got %h want deadbeef", inst); end
      checks++; if (read_data !== 32'hA5A50001) begin failures++; $display("FAIL prio_c5_data_hold: got %h want a5a50001", read_data); end
      iread_en = 1'b0;
      step();
   endtask

   task automatic test_bypass();
      write_word(32'h20, 32'h11111111);
      memaddr = 32'h20; read_en = 1'b1;
      step();
      write_en = 1'b1; write_data = 32'h12345678;
      step();
      write_en = 1'b0;
      checks++; if (read_vd !== 1'b1) begin failures++; $display("FAIL byp_entry_vd: got %b want 1", read_vd); end
      checks++; if (read_data !== 32'h12345678) begin failures++; $display("FAIL byp_entry_data: got %h want 12345678", read_data); end
      read_en = 1'b0;
      step();
      read_en = 1'b1; write_en = 1'b1; write_data = 32'hCAFEF00D;
      step();
      write_en = 1'b0;
      step();
      checks++; if (read_data !== 32'hCAFEF00D) begin failures++; $display("FAIL byp_accept_data: got %h want cafef00d", read_data); end
      read_en = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp;
      iaddr = 32'h10; iread_en = 1'b1;
      memaddr = 32'h0; write_data = 32'h100; write_en = 1'b1;
      step();
      memaddr = 32'h4; write_data = 32'h200;
      step();
      memaddr = 32'h8; write_data = 32'h300;
      checks++; if (iread_vd !== 1'b1) begin failures++; $display("FAIL b2b_fetch_vd: got %b want 1", iread_vd); end
      checks++; if (inst !== 32'hDEADBEEF) begin failures++; $display("FAIL b2b_fetch_inst: got %h want deadbeef", inst); end
      step();
      write_en = 1'b0; iread_en = 1'b0;
      step();
      for (int i = 0; i < 3; i++) begin
         exp = 32'(i + 1) * 32'h100;
         memaddr = 32'(i * 4); read_en = 1'b1;
         step(); step();
         checks++; if (read_vd !== 1'b1 || read_data !== exp) begin
            failures++; $display("FAIL b2b_readback%0d: got vd=%b data=%h want vd=1 data=%h", i, read_vd, read_data, exp);
         end
         read_en = 1'b0;
         step();
      end
   endtask

   task automatic test_reset_wait();
      iaddr = 32'h10; iread_en = 1'b1;
      step();
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rw_c1_busy: got %b want 1", busy); end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (iread_vd !== 1'b0) begin failures++; $display("FAIL rw_c2_vd: got %b want 0", iread_vd); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rw_c2_busy: got %b want 0", busy); end
      checks++; if (inst !== 32'h0) begin failures++; $display("FAIL rw_c2_inst: got %h want 0", inst); end
      step();
      checks++; if (iread_vd !== 1'b0 || busy !== 1'b1) begin
         failures++; $display("FAIL rw_c3: got vd=%b busy=%b want vd=0 busy=1", iread_vd, busy);
      end
      step();
      checks++; if (iread_vd !== 1'b1) begin failures++; $display("FAIL rw_c4_vd: got %b want 1", iread_vd); end
      checks++; if (inst !== 32'hDEADBEEF) begin failures++; $display("FAIL rw_c4_inst: got %h want deadbeef", inst); end
      iread_en = 1'b0;
      step();
   endtask

   task automatic test_wrap();
      b_memaddr = 32'h0; b_write_data = 32'h0BADF00D; b_write_en = 1'b1;
      step();
      b_write_en = 1'b0;
      b_memaddr = 32'h40; b_read_en = 1'b1;
      checks++; if (b_busy !== 1'b0) begin failures++; $display("FAIL wrap_c0_busy: got %b want 0", b_busy); end
      step();
      checks++; if (b_read_vd !== 1'b1) begin failures++; $display("FAIL wrap_c1_vd: got %b want 1", b_read_vd); end
      checks++; if (b_read_data !== 32'h0BADF00D) begin failures++; $display("FAIL wrap_c1_data: got %h want 0badf00d", b_read_data); end
      checks++; if (b_busy !== 1'b1) begin failures++; $display("FAIL wrap_c1_busy: got %b want 1", b_busy); end
      b_read_en = 1'b0;
      step();
      checks++; if (b_read_vd !== 1'b0 || b_busy !== 1'b0) begin
         failures++; $display("FAIL wrap_c2: got vd=%b busy=%b want 0 0", b_read_vd, b_busy);
      end
      b_iaddr = 32'h43; b_iread_en = 1'b1;
      step();
      checks++; if (b_iread_vd !== 1'b1 || b_inst !== 32'h0BADF00D) begin
         failures++; $display("FAIL wrap_fetch: got vd=%b inst=%h want 1 0badf00d", b_iread_vd, b_inst);
      end
      b_iread_en = 1'b0;
      step();
   endtask

   initial begin
      rst = 1'b1;
      iaddr = '0; iread_en = 1'b0; memaddr = '0; read_en = 1'b0; write_en = 1'b0; write_data = '0;
      b_iaddr = '0; b_iread_en = 1'b0; b_memaddr = '0; b_read_en = 1'b0; b_write_en = 1'b0; b_write_data = '0;
      test_reset();
      test_fetch();
      test_priority();
      test_bypass();
      test_back_to_back();
      test_reset_wait();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
